accum_readout_ctrl: RTL

ACCUM_READOUT_CTRL -- requirements
Module: accum_readout_ctrl

---
 rtl/accum_readout_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/accum_readout_ctrl.sv
// accum_readout_ctrl: serialises the accumulator/counter state into a byte
// frame (LSB, MSB, counter value, optional carry) over a valid/ready link.
// The accumulator is frozen via hold while a frame is being read out.
module accum_readout_ctrl #(
    parameter int unsigned INCLUDE_CARRY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] mux_data,
    output logic [2:0] mux_sel,
    output logic       hold,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    // Accumulator mux select encodings
    localparam logic [2:0] MUX_SEL_REGISTER_2_LSB = 3'd0;
    localparam logic [2:0] MUX_SEL_REGISTER_2_MSB = 3'd1;
    localparam logic [2:0] MUX_SEL_COUNTER_VALUE  = 3'd2;
    localparam logic [2:0] MUX_SEL_COUNTER_CARRY  = 3'd3;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Index of the final byte in the frame
    localparam logic [1:0] LAST_IDX = (INCLUDE_CARRY != 0) ? 2'd3 : 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] mux_sel_q, mux_sel_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       hold_q, hold_d;
    logic       done_q, done_d;

    // Map a byte index onto the mux encoding that presents that byte
    function automatic logic [2:0] sel_for_idx(input logic [1:0] i);
        logic [2:0] s;
        case (i)
            2'd0:    s = MUX_SEL_REGISTER_2_LSB;
            2'd1:    s = MUX_SEL_REGISTER_2_MSB;
            2'd2:    s = MUX_SEL_COUNTER_VALUE;
            default: s = MUX_SEL_COUNTER_CARRY;
        endcase
        return s;
    endfunction

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mux_sel_d   = mux_sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        hold_d      = hold_q;
        done_d      = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            // Abort wins over any handshake in the same cycle
            state_d     = ST_IDLE;
            idx_d       = 2'd0;
            mux_sel_d   = MUX_SEL_REGISTER_2_LSB;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            hold_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d   = ST_LOAD;
                        idx_d     = 2'd0;
                        mux_sel_d = MUX_SEL_REGISTER_2_LSB;
                        hold_d    = 1'b1;
                    end
                end
                ST_LOAD: begin
                    // mux_sel has had a full cycle to settle; capture the byte
                    out_data_d  = mux_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (idx_q == LAST_IDX);
                    state_d     = ST_SEND;
                end
                ST_SEND: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            out_last_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            idx_d     = idx_q + 2'd1;
                            mux_sel_d = sel_for_idx(idx_q + 2'd1);
                            state_d   = ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    hold_d    = 1'b0;
                    idx_d     = 2'd0;
                    mux_sel_d = MUX_SEL_REGISTER_2_LSB;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            mux_sel_q   <= MUX_SEL_REGISTER_2_LSB;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mux_sel_q   <= mux_sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
        end
    end

    // Output wiring
    always_comb begin
        mux_sel   = mux_sel_q;
        hold      = hold_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_last  = out_last_q;
        done      = done_q;
        busy      = (state_q != ST_IDLE);
    end

endmodule
